// File: rtl/compare_sequencer_pkg.sv
// compare_sequencer_pkg: shared FSM state type and sizing constants for the compare sequencer.
package compare_sequencer_pkg;
   typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_e;
   localparam int NBYTES_DEFAULT = 4;
   localparam int BYTE_W = 8;
endpackage

// File: rtl/compare_sequencer_byte_eq_unit.sv
// byte_eq_unit: gated byte inequality detector, neq forced low when disabled.
module byte_eq_unit
   import compare_sequencer_pkg::*;
(
   input  logic [BYTE_W-1:0] x,
   input  logic [BYTE_W-1:0] y,
   input  logic              en,
   output logic              neq
);
   assign neq = en && (x != y);
endmodule

// File: rtl/compare_sequencer.sv
// compare_sequencer: byte-serial word comparator reporting equality and the lowest mismatching byte.
// Define CMP_EARLY_EXIT_EN to finish as soon as the first mismatch is found.
module compare_sequencer
   import compare_sequencer_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT,
   parameter int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [BYTE_W*NBYTES-1:0] a_word,
   input  logic [BYTE_W*NBYTES-1:0] b_word,
   output logic                     busy,
   output logic                     done,
   output logic                     equal,
   output logic [IW-1:0]            mism_idx
);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
   state_e state_q, state_d;
   logic [BYTE_W*NBYTES-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0] idx_q, idx_d, first_q, first_d, mism_idx_q, mism_idx_d;
   logic eq_acc_q, eq_acc_d, busy_q, busy_d, done_q, done_d, equal_q, equal_d;
   logic neq, hit, accept, finish;
   byte_eq_unit u_eq (
      .x   (a_q[BYTE_W*idx_q +: BYTE_W]),
      .y   (b_q[BYTE_W*idx_q +: BYTE_W]),
      .en  (state_q == S_CMP),
      .neq (neq)
   );
   always_comb begin
      accept = (state_q == S_IDLE) && start;
      hit = neq && eq_acc_q;
`ifdef CMP_EARLY_EXIT_EN
      finish = (state_q == S_CMP) && (neq || idx_q == LAST);
`else
      finish = (state_q == S_CMP) && (idx_q == LAST);
`endif
      state_d = accept ? S_CMP : finish ? S_DONE : (state_q == S_DONE) ? S_IDLE : state_q;
      a_d = accept ? a_word : a_q;
      b_d = accept ? b_word : b_q;
      idx_d = accept ? '0 : (state_q == S_CMP && !finish) ? idx_q + 1'b1 : idx_q;
      eq_acc_d = accept ? 1'b1 : eq_acc_q && !neq;
      first_d = accept ? '0 : hit ? idx_q : first_q;
      // results are published only when the compare completes
      equal_d = accept ? 1'b0 : finish ? eq_acc_q && !neq : equal_q;
      mism_idx_d = accept ? '0 : finish ? (hit ? idx_q : first_q) : mism_idx_q;
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         idx_q      <= '0;
         first_q    <= '0;
         mism_idx_q <= '0;
         eq_acc_q   <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         equal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         idx_q      <= idx_d;
         first_q    <= first_d;
         mism_idx_q <= mism_idx_d;
         eq_acc_q   <= eq_acc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         equal_q    <= equal_d;
      end
   end
   assign busy     = busy_q;
   assign done     = done_q;
   assign equal    = equal_q;
   assign mism_idx = mism_idx_q;
endmodule

// File: tb/tb_compare_sequencer.sv
// tb_compare_sequencer: random and directed checks of a 4-byte and a 1-byte compare_sequencer against a byte-loop model.
module tb_compare_sequencer;
   logic clk = 1'b0, rst;
   logic start0, busy0, done0, equal0;
   logic [31:0] a0, b0;
   logic [1:0] mism0;
   logic start1, busy1, done1, equal1;
   logic [7:0] a1, b1;
   logic [0:0] mism1;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   compare_sequencer #(.NBYTES(4)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .a_word(a0), .b_word(b0),
      .busy(busy0), .done(done0), .equal(equal0), .mism_idx(mism0)
   );
   compare_sequencer #(.NBYTES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_word(a1), .b_word(b1),
      .busy(busy1), .done(done1), .equal(equal1), .mism_idx(mism1)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // expected result straight from the byte-wise rules: lowest differing byte, latency by mode
   function automatic void model(input int nb, input logic [31:0] a, input logic [31:0] b,
                                 output logic eq, output int idx, output int lat);
      eq = 1'b1; idx = 0; lat = nb + 1;
      for (int i = 0; i < nb; i++)
         if (a[8*i +: 8] != b[8*i +: 8]) begin
            if (eq) begin
               idx = i;
`ifdef CMP_EARLY_EXIT_EN
               lat = i + 2;
`endif
            end
            eq = 1'b0;
         end
   endfunction
   task automatic drive(input bit s, input logic st, input logic [31:0] a, input logic [31:0] b);
      if (s) begin start1 = st; a1 = a[7:0]; b1 = b[7:0]; end
      else begin start0 = st; a0 = a; b0 = b; end
   endtask
   task automatic run_cmp(input bit s, input logic [31:0] a, input logic [31:0] b, input int poke);
      logic e, gd;
      int k, l, lat, ndone;
      model(s ? 1 : 4, a, b, e, k, l);
      @(negedge clk);
      drive(s, 1'b1, a, b);
      @(negedge clk);
      drive(s, 1'b0, $urandom, $urandom);
      chk("busy_c1", s ? busy1 : busy0, 1);
      chk("eq_clr", s ? equal1 : equal0, 0);
      chk("idx_clr", s ? 32'(mism1) : 32'(mism0), 0);
      lat = 0; ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) @(negedge clk);
         drive(s, c == poke, $urandom, $urandom);
         gd = s ? done1 : done0;
         if (gd) begin lat = c; break; end
      end
      drive(s, 1'b0, $urandom, $urandom);
      chk("latency", lat, l);
      chk("equal", s ? equal1 : equal0, 32'(e));
      chk("mism_idx", s ? 32'(mism1) : 32'(mism0), k);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         gd = s ? done1 : done0;
         ndone += int'(gd);
      end
      chk("one_pulse", ndone, 0);
      chk("eq_hold", s ? equal1 : equal0, 32'(e));
      chk("idx_hold", s ? 32'(mism1) : 32'(mism0), k);
   endtask
   initial begin
      logic [31:0] ra, rb;
      int d1, d2, seen;
      rst = 1'b1;
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      #1;
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_equal", equal0, 0);
      chk("rst_idx", 32'(mism0), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_cmp(0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
      run_cmp(0, 32'h11223344, 32'h11FF3300, 0);
      run_cmp(0, 32'h00AA0000, 32'h00BB0000, 0);
      run_cmp(0, 32'hCAFEF00D, 32'hCAFEF00D, 2);
      run_cmp(0, 32'h01020304, 32'h01020305, 2);
      // abort mid-compare
      @(negedge clk);
      drive(0, 1, 32'h12345678, 32'h12345679);
      @(negedge clk);
      drive(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy0, 0);
      chk("abort_done", done0, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin @(negedge clk); seen += int'(done0); end
      chk("abort_nodone", seen, 0);
      run_cmp(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
      // held start: DONE-cycle start is ignored, one IDLE cycle between compares
      @(negedge clk);
      drive(0, 1, 32'h55667788, 32'h55667788);
      d1 = -1; d2 = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done0) begin
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
      end
      drive(0, 0, 0, 0);
      chk("b2b_first", d1, 5);
      chk("b2b_gap", d2 - d1, 6);
      repeat (10) @(negedge clk);
      for (int n = 0; n < 30; n++) begin
         ra = $urandom;
         rb = ra;
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 2) == 0) rb[8*i +: 8] = rb[8*i +: 8] ^ 8'($urandom_range(1, 255));
         run_cmp(0, ra, rb, 0);
      end
      run_cmp(1, 32'h00, 32'h01, 0);
      run_cmp(1, 32'hFF, 32'hFF, 0);
      for (int n = 0; n < 6; n++) begin
         ra = $urandom;
         run_cmp(1, ra, $urandom_range(0, 1) ? ra : ~ra, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter NBYTES, default 4, number of bytes per compared word (legal range 1..16).
REQ-002 Parameter IW, default max(1,clog2(NBYTES)), width of the byte-index outputs.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  request to compare; sampled only in IDLE.
REQ-006 Port a_word  input  8*NBYTES  operand A; byte i = bits [8i+7:8i].
REQ-007 Port b_word  input  8*NBYTES  operand B, same byte layout.
REQ-008 Port busy  output  1  high while a compare is in progress (states CMP and DONE).
REQ-009 Port done  output  1  one-cycle pulse: result is valid.
REQ-010 Port equal  output  1  result: all compared bytes matched.
REQ-011 Port mism_idx  output  IW  index of the lowest mismatching byte; 0 when equal.

Function
REQ-012 FSM states: IDLE, CMP, DONE; encoding is free.
REQ-013 IDLE with start=1: latch a_word/b_word, idx<=0, eq_acc<=1, go to CMP; operand changes after this edge have no effect.
REQ-014 CMP: exactly one byte compared per cycle through one shared byte-equality unit, enabled only in CMP; idx increments by 1 per cycle.
REQ-015 On the first mismatch, mism_idx<=idx and eq_acc<=0; later mismatches do not overwrite mism_idx.
REQ-016 CMP exits to DONE after comparing byte NBYTES-1; idx never wraps past NBYTES-1.
REQ-017 DONE lasts one cycle: done=1, equal=eq_acc; then return to IDLE.
REQ-018 Latency without early exit: done high in cycle start+NBYTES+1, counting the start-accept edge as cycle 0.
REQ-019 equal and mism_idx hold their last result until the next accepted start, then clear (equal=0, mism_idx=0) until the next DONE.
REQ-020 start while busy=1 is ignored, with no queuing; start high in the DONE cycle is also ignored.
REQ-021 start held high continuously gives back-to-back compares, with one IDLE cycle between done and the next accept.
REQ-022 NBYTES=1: CMP lasts one cycle and done appears in cycle 2.

Reset
REQ-023 rst=1 forces IDLE, busy=0, done=0, equal=0, mism_idx=0, idx=0, and clears the latched operands asynchronously.
REQ-024 Reset during CMP or DONE aborts the compare; no done pulse is produced for it.
REQ-025 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro CMP_EARLY_EXIT_EN defined: CMP goes to DONE in the cycle after the first mismatch, so done appears at cycle k+2 for mismatch index k.
REQ-027 CMP_EARLY_EXIT_EN undefined: all NBYTES bytes are always compared, giving fixed latency (REQ-018) independent of data.

Structure
REQ-028 A shared package holds the state enum type and the constants NBYTES_DEFAULT and BYTE_W=8.
REQ-029 One sub-module byte_eq_unit is instantiated once: 8-bit inputs x and y, enable en, output neq. It is combinational, and neq=0 when en=0.
REQ-030 No tri-state or bidirectional nets inside the block; all outputs are always driven.

Verification
REQ-031 a_word=32'hDEADBEEF, b_word=32'hDEADBEEF, start pulse -> done at cycle 5, equal=1, mism_idx=0.
REQ-032 a_word=32'h11223344, b_word=32'h11FF3300, without early exit -> done at cycle 5, equal=0, mism_idx=0 (lowest mismatch wins).
REQ-033 Same operands with CMP_EARLY_EXIT_EN -> done at cycle 2, equal=0, mism_idx=0. Operands 32'h00AA0000 vs 32'h00BB0000 -> done at cycle 4, mism_idx=2.
REQ-034 Second start pulse during cycle 2 of an active compare -> ignored; exactly one done pulse, and the result matches the first operands.
REQ-035 rst asserted in cycle 3 of a compare -> busy=0 immediately, no done pulse. A new start after release completes normally at cycle 5.
REQ-036 NBYTES=1, a=8'h00, b=8'h01 -> done at cycle 2, equal=0, mism_idx=0. Then a=b=8'hFF -> equal=1.
